mem_stage: RTL and testbench

Memory stage of the five-stage MIPS pipeline: the consumer of everything the execute stage produces. It captures the execute results into an EX/MEM pipeline register and resolves the branch decision. It performs the data-memory load or store, then captures load data, ALU result and write-back controls into a MEM/WB register for the write-back stage. It owns the data memory array.

---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_stage_data_memory.sv | 26 ++
 rtl/mem_stage.sv | 103 ++++++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MIPS memory stage: widths, control bundle
// and the pipeline register layouts used between EX/MEM and MEM/WB.
package mem_stage_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  typedef struct packed {
    logic branch;
    logic memRead;
    logic memWrite;
    logic regWrite;
    logic memtoReg;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic [WORD_W-1:0] brachAdr;
    logic              zero;
    logic [WORD_W-1:0] aluRes;
    logic [WORD_W-1:0] storeData;
    logic [REG_W-1:0]  writeReg;
    ctrl_t             ctrl;
  } exmem_t;

  typedef struct packed {
    logic [WORD_W-1:0] memData;
    logic [WORD_W-1:0] aluRes;
    logic [REG_W-1:0]  writeReg;
    logic              regWrite;
    logic              memtoReg;
  } memwb_t;

  // Only accesses that actually touch memory can be misaligned.
  function automatic logic is_misaligned(input logic [1:0] lowBits, input ctrl_t c);
    return ((lowBits & MISALIGN_MASK) != 2'b00) && (c.memRead || c.memWrite);
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read, so a read
// in the same cycle as a write to the same word returns the old contents.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, branch resolution, data-memory access
// with misalignment protection, and the MEM/WB register feeding write-back.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [WORD_W-1:0] brachAdr,
  input  logic              zero,
  input  logic [WORD_W-1:0] ALUres,
  input  logic [WORD_W-1:0] reg21,
  input  logic [REG_W-1:0]  writeReg,
  input  logic              Branch,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              flush,
  output logic              PCSrc,
  output logic [WORD_W-1:0] branchTarget,
  output logic [WORD_W-1:0] memData,
  output logic [WORD_W-1:0] aluResWB,
  output logic [REG_W-1:0]  writeRegWB,
  output logic              RegWriteWB,
  output logic              MemtoRegWB,
  output logic              misalignErr
);

  exmem_t                 exmem;
  memwb_t                 memwb;
  logic [CTRL_W-1:0]      ctrlBits;
  ctrl_t                  ctrlIn;
  logic                   misaligned;
  logic                   memWe;
  logic [ADDR_BITS-1:0]   memIndex;
  logic [WORD_W-1:0]      readWord;
  logic                   misalignSticky;

  assign ctrlBits = {Branch, MemRead, MemWrite, RegWrite, MemtoReg};
  assign ctrlIn   = flush ? CTRL_BUBBLE : ctrl_t'(ctrlBits);

  // A flush only kills the control bits; data fields are captured regardless.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      exmem <= '0;
    end else begin
      exmem.brachAdr  <= brachAdr;
      exmem.zero      <= zero;
      exmem.aluRes    <= ALUres;
      exmem.storeData <= reg21;
      exmem.writeReg  <= writeReg;
      exmem.ctrl      <= ctrlIn;
    end
  end

  assign misaligned = is_misaligned(exmem.aluRes[1:0], exmem.ctrl);
  assign memIndex   = exmem.aluRes[ADDR_BITS+1:2];
  assign memWe      = exmem.ctrl.memWrite && !misaligned;

  data_memory #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_data_memory (
    .clock (clock),
    .we    (memWe),
    .addr  (memIndex),
    .wdata (exmem.storeData),
    .rdata (readWord)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      memwb <= '0;
    end else begin
      memwb.memData  <= (exmem.ctrl.memRead && !misaligned) ? readWord : '0;
      memwb.aluRes   <= exmem.aluRes;
      memwb.writeReg <= exmem.writeReg;
      memwb.regWrite <= exmem.ctrl.regWrite && !misaligned;
      memwb.memtoReg <= exmem.ctrl.memtoReg;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      misalignSticky <= 1'b0;
    end else if (misaligned) begin
      misalignSticky <= 1'b1;
    end
  end

  assign PCSrc        = exmem.ctrl.branch && exmem.zero;
  assign branchTarget = exmem.brachAdr;
  assign memData      = memwb.memData;
  assign aluResWB     = memwb.aluRes;
  assign writeRegWB   = memwb.writeReg;
  assign RegWriteWB   = memwb.regWrite;
  assign MemtoRegWB   = memwb.memtoReg;
  assign misalignErr  = misalignSticky;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  localparam logic [4:0] C_BR  = 5'b10000;
  localparam logic [4:0] C_RD  = 5'b01000;
  localparam logic [4:0] C_WR  = 5'b00100;
  localparam logic [4:0] C_RW  = 5'b00010;
  localparam logic [4:0] C_M2R = 5'b00001;

  logic        clock;
  logic        resetn;
  logic [31:0] brachAdr;
  logic        zero;
  logic [31:0] ALUres;
  logic [31:0] reg21;
  logic [4:0]  writeReg;
  logic        Branch, MemRead, MemWrite, RegWrite, MemtoReg;
  logic        flush;
  logic        PCSrc;
  logic [31:0] branchTarget;
  logic [31:0] memData;
  logic [31:0] aluResWB;
  logic [4:0]  writeRegWB;
  logic        RegWriteWB, MemtoRegWB;
  logic        misalignErr;
  logic [104:0] allOuts;

  int compared = 0;
  int mismatched = 0;

  mem_stage #(.DEPTH(256), .ADDR_BITS(8)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .brachAdr     (brachAdr),
    .zero         (zero),
    .ALUres       (ALUres),
    .reg21        (reg21),
    .writeReg     (writeReg),
    .Branch       (Branch),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .RegWrite     (RegWrite),
    .MemtoReg     (MemtoReg),
    .flush        (flush),
    .PCSrc        (PCSrc),
    .branchTarget (branchTarget),
    .memData      (memData),
    .aluResWB     (aluResWB),
    .writeRegWB   (writeRegWB),
    .RegWriteWB   (RegWriteWB),
    .MemtoRegWB   (MemtoRegWB),
    .misalignErr  (misalignErr)
  );

  assign allOuts = {PCSrc, branchTarget, memData, aluResWB, writeRegWB,
                    RegWriteWB, MemtoRegWB, misalignErr};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [31:0] adr, input logic z,
                               input logic [31:0] alu, input logic [31:0] data,
                               input logic [4:0] wreg, input logic [4:0] ctrl,
                               input logic fl);
    brachAdr = adr;
    zero     = z;
    ALUres   = alu;
    reg21    = data;
    writeReg = wreg;
    {Branch, MemRead, MemWrite, RegWrite, MemtoReg} = ctrl;
    flush    = fl;
  endtask

  task automatic bubble();
    applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 5'b00000, 1'b0);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    bubble();
    #2 resetn = 1'b0;
    #1;
    compared++;
    if (allOuts !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", allOuts);
    end
    cycle();
    cycle();
    compared++;
    if (allOuts !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_held: got %h expected 0", allOuts);
    end
    @(negedge clock);
    resetn = 1'b1;
    cycle();
    compared++;
    if (allOuts !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_release_bubble: got %h expected 0", allOuts);
    end
  endtask

  task automatic test_store_load();
    applyStimulus(32'h0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, C_WR, 1'b0);
    cycle();
    applyStimulus(32'h0, 1'b0, 32'h10, 32'h0, 5'd7, C_RD | C_RW | C_M2R, 1'b0);
    cycle();
    bubble();
    cycle();
    compared++;
    if (memData !== 32'hDEADBEEF) begin
      mismatched++;
      $display("[TB] FAIL store_load_data: got %h expected DEADBEEF", memData);
    end
    compared++;
    if ({writeRegWB, RegWriteWB, MemtoRegWB} !== {5'd7, 1'b1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL store_load_ctrl: got %h/%b/%b expected 07/1/1",
               writeRegWB, RegWriteWB, MemtoRegWB);
    end
    compared++;
    if (aluResWB !== 32'h10) begin
      mismatched++;
      $display("[TB] FAIL store_load_alures: got %h expected 00000010", aluResWB);
    end
  endtask

  task automatic test_branch();
    applyStimulus(32'h40, 1'b1, 32'h0, 32'h0, 5'd0, C_BR, 1'b0);
    cycle();
    compared++;
    if ({PCSrc, branchTarget} !== {1'b1, 32'h40}) begin
      mismatched++;
      $display("[TB] FAIL branch_taken: got %b/%h expected 1/00000040", PCSrc, branchTarget);
    end
    applyStimulus(32'h80, 1'b0, 32'h0, 32'h0, 5'd0, C_BR, 1'b0);
    cycle();
    compared++;
    if ({PCSrc, branchTarget} !== {1'b0, 32'h80}) begin
      mismatched++;
      $display("[TB] FAIL branch_not_taken: got %b/%h expected 0/00000080", PCSrc, branchTarget);
    end
    applyStimulus(32'hC0, 1'b1, 32'h0, 32'h0, 5'd0, 5'b00000, 1'b0);
    cycle();
    compared++;
    if (PCSrc !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL branch_zero_only: got %b expected 0", PCSrc);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(32'h0, 1'b0, 32'h400, 32'h1234, 5'd0, C_WR, 1'b0);
    cycle();
    applyStimulus(32'h0, 1'b0, 32'h000, 32'h0, 5'd4, C_RD | C_RW | C_M2R, 1'b0);
    cycle();
    bubble();
    cycle();
    compared++;
    if (memData !== 32'h1234) begin
      mismatched++;
      $display("[TB] FAIL wrap_load: got %h expected 00001234", memData);
    end
    compared++;
    if (misalignErr !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL wrap_no_err: got %b expected 0", misalignErr);
    end
  endtask

  task automatic test_misaligned();
    applyStimulus(32'h0, 1'b0, 32'h13, 32'h5555, 5'd0, C_WR, 1'b0);
    cycle();
    bubble();
    cycle();
    compared++;
    if (misalignErr !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL misalign_store_err: got %b expected 1", misalignErr);
    end
    applyStimulus(32'h0, 1'b0, 32'h11, 32'h0, 5'd5, C_RD | C_RW | C_M2R, 1'b0);
    cycle();
    bubble();
    cycle();
    compared++;
    if ({memData, RegWriteWB} !== {32'h0, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL misalign_load: got %h/%b expected 00000000/0", memData, RegWriteWB);
    end
    applyStimulus(32'h0, 1'b0, 32'h10, 32'h0, 5'd6, C_RD | C_RW | C_M2R, 1'b0);
    cycle();
    bubble();
    cycle();
    compared++;
    if ({memData, RegWriteWB} !== {32'hDEADBEEF, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL misalign_mem_unchanged: got %h/%b expected DEADBEEF/1", memData, RegWriteWB);
    end
    compared++;
    if (misalignErr !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL misalign_sticky: got %b expected 1", misalignErr);
    end
  endtask

  task automatic test_flush();
    applyStimulus(32'h44, 1'b1, 32'h10, 32'hBAD0BAD0, 5'd3, C_BR | C_WR | C_RW, 1'b1);
    cycle();
    compared++;
    if ({PCSrc, branchTarget} !== {1'b0, 32'h44}) begin
      mismatched++;
      $display("[TB] FAIL flush_branch: got %b/%h expected 0/00000044", PCSrc, branchTarget);
    end
    applyStimulus(32'h0, 1'b0, 32'h10, 32'h0, 5'd8, C_RD | C_RW, 1'b0);
    cycle();
    compared++;
    if ({RegWriteWB, writeRegWB, aluResWB} !== {1'b0, 5'd3, 32'h10}) begin
      mismatched++;
      $display("[TB] FAIL flush_wb: got %b/%h/%h expected 0/03/00000010", RegWriteWB, writeRegWB, aluResWB);
    end
    bubble();
    cycle();
    compared++;
    if (memData !== 32'hDEADBEEF) begin
      mismatched++;
      $display("[TB] FAIL flush_no_store: got %h expected DEADBEEF", memData);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(32'h0, 1'b0, 32'h20, 32'hCAFEF00D, 5'd0, C_WR, 1'b0);
    cycle();
    applyStimulus(32'h0, 1'b0, 32'h20, 32'h11111111, 5'd9, C_RD | C_WR, 1'b0);
    cycle();
    applyStimulus(32'h0, 1'b0, 32'h20, 32'h0, 5'd10, C_RD | C_RW, 1'b0);
    cycle();
    compared++;
    if (memData !== 32'hCAFEF00D) begin
      mismatched++;
      $display("[TB] FAIL read_before_write: got %h expected CAFEF00D", memData);
    end
    bubble();
    cycle();
    compared++;
    if (memData !== 32'h11111111) begin
      mismatched++;
      $display("[TB] FAIL rw_write_committed: got %h expected 11111111", memData);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(32'h0, 1'b0, 32'h30, 32'h77777777, 5'd0, C_WR, 1'b0);
    cycle();
    applyStimulus(32'h90, 1'b1, 32'h30, 32'h88888888, 5'd9, C_BR | C_WR, 1'b0);
    cycle();
    compared++;
    if (PCSrc !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_branch: got %b expected 1", PCSrc);
    end
    bubble();
    #2 resetn = 1'b0;
    #1;
    compared++;
    if (allOuts !== '0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_outputs: got %h expected 0", allOuts);
    end
    cycle();
    @(negedge clock);
    resetn = 1'b1;
    applyStimulus(32'h0, 1'b0, 32'h30, 32'h0, 5'd2, C_RD | C_RW | C_M2R, 1'b0);
    cycle();
    bubble();
    cycle();
    compared++;
    if ({memData, RegWriteWB} !== {32'h77777777, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_no_commit: got %h/%b expected 77777777/1", memData, RegWriteWB);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_branch();
    test_wrap();
    test_misaligned();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
